// File: rtl/axis_coincidence_reader.sv
// Multi-plane coincidence detector: delays strip hits, ORs them over a window,
// emits {timestamp, pattern} on AXI4-Stream. Optional macro: AXIS_COINC_EDGE_MASK_EN.
module axis_coincidence_reader #(
  parameter int PLANES       = 4,
  parameter int PLANE_WIDTH  = 16,
  parameter int DELAY        = 5,
  parameter int WINDOW_WIDTH = 8
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [PLANES*PLANE_WIDTH-1:0]       det_data,
  input  logic [3:0]                          cfg_level,
  input  logic [WINDOW_WIDTH-1:0]             cfg_window,
  input  logic [PLANES-1:0]                   cfg_plane_mask,
  input  logic                                m_axis_tready,
  output logic [64+PLANES*PLANE_WIDTH-1:0]    m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic [31:0]                         sts_lost
);

  // state    | meaning
  // IDLE     | wait for first nonzero hit (trigger)
  // COLLECT  | OR further hits into the pattern until the window closes
  // OR       | reduce pattern to per-plane fired flags
  // SUM      | count fired planes
  // DECIDE   | compare count against cfg_level
  // SEND     | hold event word until downstream accepts it
  typedef enum logic [2:0] {
    ST_IDLE, ST_COLLECT, ST_OR, ST_SUM, ST_DECIDE, ST_SEND
  } state_t;

  localparam int DW = PLANES * PLANE_WIDTH;
  localparam int SW = $clog2(PLANES + 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DW-1:0]           r_pipe [DELAY];
  logic [DW-1:0]           w_keep;
  logic [DW-1:0]           w_hit;
  logic                    w_any_hit;
  logic [63:0]             r_time;
  logic [63:0]             r_ts;
  logic [DW-1:0]           r_acc;
  logic [WINDOW_WIDTH-1:0] r_remain;
  logic [PLANES-1:0]       w_flag;
  logic [PLANES-1:0]       r_flag;
  logic [SW-1:0]           w_sum;
  logic [SW-1:0]           r_sum;
  logic                    w_accept;
  logic [64+DW-1:0]        r_tdata;
  logic                    r_tvalid;
  logic [31:0]             r_lost;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < DELAY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= det_data;
      for (int i = 1; i < DELAY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    w_keep = '0;
    for (int p = 0; p < PLANES; p++) begin
      w_keep[p*PLANE_WIDTH +: PLANE_WIDTH] = {PLANE_WIDTH{cfg_plane_mask[p]}};
`ifdef AXIS_COINC_EDGE_MASK_EN
      w_keep[p*PLANE_WIDTH]                 = 1'b0;
      w_keep[p*PLANE_WIDTH + PLANE_WIDTH-1] = 1'b0;
`endif
    end
  end

  assign w_hit     = r_pipe[DELAY-1] & w_keep;
  assign w_any_hit = |w_hit;

  always_comb begin
    w_flag = '0;
    for (int p = 0; p < PLANES; p++) w_flag[p] = |r_acc[p*PLANE_WIDTH +: PLANE_WIDTH];
  end

  always_comb begin
    w_sum = '0;
    for (int p = 0; p < PLANES; p++) w_sum = w_sum + SW'(r_flag[p]);
  end

  assign w_accept = (5'(r_sum) >= 5'(cfg_level));

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_any_hit) w_state_nxt = (cfg_window == '0) ? ST_OR : ST_COLLECT;
      ST_COLLECT: if (r_remain == WINDOW_WIDTH'(1)) w_state_nxt = ST_OR;
      ST_OR:      w_state_nxt = ST_SUM;
      ST_SUM:     w_state_nxt = ST_DECIDE;
      ST_DECIDE:  w_state_nxt = w_accept ? ST_SEND : ST_IDLE;
      ST_SEND:    if (m_axis_tready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_time   <= '0;
      r_ts     <= '0;
      r_acc    <= '0;
      r_remain <= '0;
      r_flag   <= '0;
      r_sum    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_lost   <= '0;
    end else begin
      r_time <= r_time + 64'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_any_hit) begin
            r_ts     <= r_time;
            r_acc    <= w_hit;
            r_remain <= cfg_window;
          end
        end
        // remaining window cycles count down; the window closes at terminal count 1
        ST_COLLECT: begin
          r_acc    <= r_acc | w_hit;
          r_remain <= r_remain - WINDOW_WIDTH'(1);
        end
        ST_OR:  r_flag <= w_flag;
        ST_SUM: r_sum  <= w_sum;
        ST_DECIDE: begin
          if (w_accept) begin
            r_tvalid <= 1'b1;
            r_tdata  <= {r_ts, r_acc};
          end
        end
        ST_SEND: begin
          if (m_axis_tready) r_tvalid <= 1'b0;
          else if (w_any_hit && (r_lost != 32'hFFFF_FFFF)) r_lost <= r_lost + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign sts_lost      = r_lost;

endmodule
